// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared constants and state encodings for the command
// driven program loader (prog_loader_cmd) and its write timer.
//   - OP_*     : command opcodes recognised in the CMD state
//   - pstate_e : byte-stream parser states
//   - wstate_e : memory write timing states
package prog_loader_pkg;

    localparam logic [7:0] OP_SET_ADR = 8'hA0;
    localparam logic [7:0] OP_WRITE   = 8'hB0;
    localparam logic [7:0] OP_CLEAR   = 8'hC0;

    typedef enum logic [2:0] {
        P_CMD,
        P_ADR,
        P_LEN0,
        P_LEN1,
        P_DATA
    } pstate_e;

    typedef enum logic [2:0] {
        W_IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD,
        W_INC
    } wstate_e;

endpackage

// File: rtl/prog_write_timer.sv
// prog_write_timer: sequences one memory write per handed-off byte with
// programmable setup / pulse / hold phases, then one address-increment cycle.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start_i    : hand a byte to the writer (honoured only while idle)
//   byte_i     : byte to write
//   data_o     : latched write data
//   write_o    : write strobe (forced low while reset is high)
//   inc_o      : high for the single address-increment cycle
//   idle_o     : writer can accept a new byte this cycle
module prog_write_timer
    import prog_loader_pkg::*;
#(
    parameter int T_SETUP = 0,
    parameter int T_PULSE = 1,
    parameter int T_HOLD  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    output logic [7:0] data_o,
    output logic       write_o,
    output logic       inc_o,
    output logic       idle_o
);

    if (T_PULSE < 1 || T_PULSE > 15 || T_SETUP < 0 || T_SETUP > 15 ||
        T_HOLD < 0 || T_HOLD > 15) begin : g_bad_timing
        $error("prog_write_timer: timing parameter out of range");
    end

    // Terminal phase counts; a zero-length phase is skipped entirely so its
    // terminal value is never compared.
    localparam logic [3:0] SETUP_LAST = 4'(T_SETUP - 1);
    localparam logic [3:0] PULSE_LAST = 4'(T_PULSE - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(T_HOLD - 1);

    wstate_e    st_q, st_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q + 4'd1;
        data_d = data_q;
        case (st_q)
            W_IDLE: begin
                cnt_d = '0;
                if (start_i) begin
                    data_d = byte_i;
                    st_d   = (T_SETUP > 0) ? W_SETUP : W_PULSE;
                end
            end
            W_SETUP: if (cnt_q == SETUP_LAST) begin
                cnt_d = '0;
                st_d  = W_PULSE;
            end
            W_PULSE: if (cnt_q == PULSE_LAST) begin
                cnt_d = '0;
                st_d  = (T_HOLD > 0) ? W_HOLD : W_INC;
            end
            W_HOLD: if (cnt_q == HOLD_LAST) begin
                cnt_d = '0;
                st_d  = W_INC;
            end
            default: begin
                cnt_d = '0;
                st_d  = W_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q  <= W_IDLE;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    // Write data carries no reset value; it is only meaningful under write.
    always_ff @(posedge clk) data_q <= data_d;

    assign data_o  = data_q;
    // Gate with reset so a reset mid-pulse cuts the strobe immediately.
    assign write_o = (st_q == W_PULSE) && !reset;
    assign inc_o   = (st_q == W_INC);
    assign idle_o  = (st_q == W_IDLE);

endmodule

// File: rtl/prog_loader_cmd.sv
// prog_loader_cmd: command-driven program loader. Decodes bytes from the UART
// receiver (toggle handshake) into SET_ADR / WRITE / CLEAR commands and drives
// a timed memory write port, with a one-byte buffer in front of the writer.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   data_rx           : received byte
//   data_rx_seq       : toggles once per new byte
//   adr, data, write  : memory write port
//   busy              : parser mid-command, writer active or buffer full
//   done              : one-cycle pulse after the last byte of a block
//   checksum          : mod-256 sum of written bytes since reset / CLEAR
//   overrun, cmd_err  : sticky error flags, cleared by CLEAR
module prog_loader_cmd
    import prog_loader_pkg::*;
#(
    parameter int ADR_WIDTH = 21,
    parameter int T_SETUP   = 0,
    parameter int T_PULSE   = 1,
    parameter int T_HOLD    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           data_rx,
    input  logic                 data_rx_seq,
    output logic [ADR_WIDTH-1:0] adr,
    output logic [7:0]           data,
    output logic                 write,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           checksum,
    output logic                 overrun,
    output logic                 cmd_err
);

    localparam int         ADR_BYTES = (ADR_WIDTH + 7) / 8;
    localparam int         SH_W      = ADR_BYTES * 8;
    localparam logic [3:0] IDX_LAST  = 4'(ADR_BYTES - 1);

    pstate_e              ps_q, ps_d;
    logic                 last_seq_q;
    logic [3:0]           idx_q, idx_d;
    logic [16:0]          rem_q, rem_d;       // bytes still to accept in block
    logic [7:0]           len_lo_q, len_lo_d;
    logic [SH_W-1:0]      sh_q, sh_d, sh_ins;
    logic [ADR_WIDTH-1:0] adr_q, adr_d;
    logic                 pend_vld_q, pend_vld_d;
    logic [7:0]           pend_q, pend_d;
    logic [7:0]           chk_q, chk_d;
    logic                 ovr_q, ovr_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;

    logic       rx_new, clr, start;
    logic [7:0] start_byte;
    logic       w_inc, w_idle;

    assign rx_new = (data_rx_seq != last_seq_q);

    prog_write_timer #(
        .T_SETUP (T_SETUP),
        .T_PULSE (T_PULSE),
        .T_HOLD  (T_HOLD)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .start_i (start),
        .byte_i  (start_byte),
        .data_o  (data),
        .write_o (write),
        .inc_o   (w_inc),
        .idle_o  (w_idle)
    );

    always_comb begin
        ps_d       = ps_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        len_lo_d   = len_lo_q;
        sh_d       = sh_q;
        adr_d      = adr_q;
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;
        chk_d      = chk_q;
        ovr_d      = ovr_q;
        err_d      = err_q;
        done_d     = 1'b0;
        clr        = 1'b0;
        start      = 1'b0;
        start_byte = pend_q;

        sh_ins = sh_q;
        sh_ins[{idx_q, 3'b000} +: 8] = data_rx;

        // Address increment after each write; an ADR load below overrides it.
        if (w_inc) adr_d = adr_q + 1'b1;

        // The buffered byte goes first so the writer restarts without a gap.
        if (w_idle && pend_vld_q) begin
            start      = 1'b1;
            start_byte = pend_q;
            pend_vld_d = 1'b0;
        end

        if (rx_new) begin
            case (ps_q)
                P_CMD: begin
                    case (data_rx)
                        OP_SET_ADR: begin
                            ps_d  = P_ADR;
                            idx_d = '0;
                        end
                        OP_WRITE: ps_d  = P_LEN0;
                        OP_CLEAR: clr   = 1'b1;
                        default:  err_d = 1'b1;
                    endcase
                end
                P_ADR: begin
                    sh_d = sh_ins;
                    if (idx_q == IDX_LAST) begin
                        adr_d = sh_ins[ADR_WIDTH-1:0];
                        ps_d  = P_CMD;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
                P_LEN0: begin
                    len_lo_d = data_rx;
                    ps_d     = P_LEN1;
                end
                P_LEN1: begin
                    rem_d = {1'b0, data_rx, len_lo_q} + 17'd1;
                    ps_d  = P_DATA;
                end
                default: begin
                    // Extra bytes after the block count is exhausted are ignored.
                    if (rem_q != '0) begin
                        if (w_idle && !pend_vld_q) begin
                            start      = 1'b1;
                            start_byte = data_rx;
                            rem_d      = rem_q - 17'd1;
                        end else if (!pend_vld_q || w_idle) begin
                            // Empty buffer, or buffer draining this very cycle.
                            pend_vld_d = 1'b1;
                            pend_d     = data_rx;
                            rem_d      = rem_q - 17'd1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end
                end
            endcase
        end

        // Block ends once every byte was accepted and the last write retires.
        if (ps_q == P_DATA && rem_q == '0 && w_inc && !pend_vld_q) begin
            done_d = 1'b1;
            ps_d   = P_CMD;
        end

        if (start) chk_d = chk_q + start_byte;

        if (clr) begin
            chk_d = '0;
            ovr_d = 1'b0;
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // Track the toggle even in reset so stale history is never a byte.
        last_seq_q <= data_rx_seq;
        if (reset) begin
            ps_q       <= P_CMD;
            idx_q      <= '0;
            rem_q      <= '0;
            len_lo_q   <= '0;
            sh_q       <= '0;
            adr_q      <= '0;
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
            chk_q      <= '0;
            ovr_q      <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ps_q       <= ps_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            len_lo_q   <= len_lo_d;
            sh_q       <= sh_d;
            adr_q      <= adr_d;
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
            chk_q      <= chk_d;
            ovr_q      <= ovr_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    // CLEAR only decodes in CMD and handoffs only happen in DATA.
    a_clr_vs_start: assert property (@(posedge clk) disable iff (reset) !(clr && start));

    assign adr      = adr_q;
    assign busy     = (ps_q != P_CMD) || !w_idle || pend_vld_q;
    assign done     = done_q;
    assign checksum = chk_q;
    assign overrun  = ovr_q;
    assign cmd_err  = err_q;

endmodule

// File: doc/prog_loader_cmd.md
Name: prog_loader_cmd

Overview:
Command-driven successor to the flat byte-stream program loader. It consumes bytes from the UART receiver over the toggle (`data_rx_seq`) handshake and decodes a small command protocol: set address, block write, clear status. It drives a memory write port with parametrised setup, pulse and hold timing. It buffers one byte while a write is in flight, and reports a running checksum, a busy flag and sticky error flags to the debug/host side.

Parameters:
ADR_WIDTH, 21, width of the memory address bus; `ADR_BYTES = ceil(ADR_WIDTH/8)`, derived.
T_SETUP, 0, cycles with `adr`/`data` stable and `write`=0 before the pulse (0..15).
T_PULSE, 1, cycles `write` is held high (1..15; 0 is illegal, elaboration error).
T_HOLD, 1, cycles with `write`=0 after the pulse, before the address increment (0..15).

Ports:
clk  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
data_rx  in  8  received byte; valid when `data_rx_seq` toggles.
data_rx_seq  in  1  toggles once per new byte on `data_rx`.
adr  out  ADR_WIDTH  memory write address.
data  out  8  memory write data.
write  out  1  write strobe.
busy  out  1  high when the parser is not in CMD, the writer is not idle, or the pending buffer is full.
done  out  1  one-cycle pulse after the last byte of a block has been written.
checksum  out  8  modulo-256 sum of all bytes written since the last reset or CLEAR.
overrun  out  1  sticky; a byte arrived while the pending buffer was already full.
cmd_err  out  1  sticky; an unknown opcode was received.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high.
- Reset values:
  - `adr`=0, `write`=0, `done`=0, `busy`=0, `checksum`=0, `overrun`=0, `cmd_err`=0.
  - `data` is don't-care.
  - Parser state CMD, writer state W_IDLE, pending buffer empty.
  - `last_seq` <= `data_rx_seq`, so no spurious byte is seen after reset.
- While `reset`=1, `write` is forced 0 combinationally. Reset mid-pulse truncates the pulse in the same cycle.
- Byte detect: when `data_rx_seq` != `last_seq` in cycle t, the byte is taken at edge t and `last_seq` is updated.
- Parser states and transitions:
  - CMD: opcode 0xA0 -> ADR (byte count = `ADR_BYTES`). Opcode 0xB0 -> LEN0. Opcode 0xC0 clears `checksum`, `overrun` and `cmd_err`, stays in CMD. Any other opcode sets `cmd_err`, stays in CMD.
  - ADR: collects `ADR_BYTES` bytes, little-endian, into a shadow register. `adr` is loaded only after the last byte; bits above `ADR_WIDTH` are discarded. Returns to CMD.
  - LEN0 / LEN1: collect 16-bit `L`, little-endian. The block contains L+1 bytes (1..65536). Go to DATA.
  - DATA: each byte is handed to the writer. When the remaining count reaches 0 and the writer finishes W_INC, `done`=1 for one cycle and the parser returns to CMD.
- Writer states:
  - W_IDLE: on a handoff, `data` <= byte at edge t. `checksum` += byte (mod 256). Go to W_SETUP, or to W_PULSE if `T_SETUP`=0.
  - W_SETUP: `T_SETUP` cycles.
  - W_PULSE: `write`=1 for `T_PULSE` cycles.
  - W_HOLD: `T_HOLD` cycles.
  - W_INC: one cycle; `adr` <= `adr`+1, wrapping modulo 2^`ADR_WIDTH`. Then W_IDLE.
- Default-timing latency: toggle seen in cycle t -> `write` high in cycle t+1 -> `adr` increments at the end of cycle t+3. Minimum spacing between bytes is 4 cycles (2+`T_SETUP`+`T_PULSE`+`T_HOLD` in general).
- Pending buffer (one byte):
  - A byte arriving in DATA while the writer is not idle is stored.
  - The writer takes the pending byte directly from W_INC -> W_IDLE in the next cycle (no idle gap).
  - A further byte arriving while pending is full: the byte is dropped, `overrun`=1, and the byte is not counted against L.
  - Bytes arriving in non-DATA states are consumed the same cycle.
- Simultaneous events:
  - Pending drain and a new arrival in the same cycle: the new byte is stored, no overrun.
  - CLEAR on the same edge as a `checksum` update: CLEAR wins. This is unreachable in practice because the parser is in CMD, so it is covered by assertion only.

Decomposition:
- Package `prog_loader_pkg`:
  - Opcode constants `OP_SET_ADR`=8'hA0, `OP_WRITE`=8'hB0, `OP_CLEAR`=8'hC0.
  - Parser state encodings (CMD, ADR, LEN0, LEN1, DATA).
  - Writer state encodings (W_IDLE, W_SETUP, W_PULSE, W_HOLD, W_INC).
- One sub-module `prog_write_timer`:
  - Writer FSM plus phase counter.
  - Inputs: start, byte.
  - Outputs: `data`, `write`, inc, idle.
- Parser, pending buffer, address register and flags stay in the top level.

Test Plan:
1. Default timing, `ADR_WIDTH`=21: send A0 34 12 00, then B0 02 00 11 22 33 -> writes 0x11@0x001234, 0x22@0x001235, 0x33@0x001236; each `write` is a single cycle; `done` pulses once; `checksum`=0x66; final `adr`=0x001237.
2. Wrap-around: A0 FF FF 1F, then B0 01 00 AA BB -> AA@0x1FFFFF, BB@0x000000; final `adr`=0x000001.
3. Overrun, with `T_PULSE`=4: three bytes toggled on consecutive cycles in DATA -> first written, second pending, third dropped; `overrun`=1; block stays open for one more byte. Then send C0 -> `overrun`=0, `checksum`=0.
4. Unknown opcode 0x55 -> `cmd_err`=1, no write; a following A0 01 00 00 loads `adr`=1.
5. Reset asserted in the 2nd cycle of the pulse with `T_PULSE`=3 -> `write`=0 that cycle; `adr`=0 next cycle; no byte detected after reset release despite prior toggle history.
6. `T_SETUP`=2, `T_HOLD`=0: toggle in cycle t -> `write` high in cycle t+3 only.
